// File: rtl/bram_pkg.sv
// Shared memory-block constants and elaboration-time helpers.
package bram_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_W = 10;

    // Ceiling log2 for sizing address and counter fields.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (val > 0) ? val - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port, no reset.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; the output register holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on a registered-read block RAM.
// The presented word is the RAM read register itself, so a pop that finds
// another word in memory re-reads on the same edge and out_valid stays high.
module bram_fifo
    import bram_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned AFULL_LVL = 1020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count,
    output logic              almost_full
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_LVL);

    // Output stage: EMPTY (nothing presented), FETCH (read issued this cycle,
    // data lands next edge), VALID (read register holds the oldest word).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] wptr_q,      wptr_d;
    logic [ADDR_W-1:0] rptr_q,      rptr_d;
    logic [ADDR_W:0]   mem_cnt_q,   mem_cnt_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              afull_q,     afull_d;

    logic              push;
    logic              pop;
    logic              rd_en;
    logic              mem_nonempty;
    logic [WIDTH-1:0]  rd_data;

    bram_sdp #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wptr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rptr_q),
        .rd_data (rd_data)
    );

    // Handshakes, output-stage next state, pointer and counter updates.
    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        push         = in_valid && in_ready_q;
        pop          = out_valid_q && out_ready;
        mem_nonempty = (mem_cnt_q != '0);

        case (state_q)
            ST_EMPTY: begin
                if (mem_nonempty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (pop) begin
                    if (mem_nonempty) begin
                        rd_en   = 1'b1;
                        state_d = ST_VALID;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        wptr_d = push  ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d = rd_en ? rptr_q + ADDR_W'(1) : rptr_q;

        case ({push, rd_en})
            2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_W + 1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_W + 1)'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d < DEPTH_C);
        afull_d     = (count_d >= AFULL_C);
        out_valid_d = (state_d == ST_VALID);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_cnt_q   <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_cnt_q   <= mem_cnt_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            afull_q     <= afull_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? rd_data : '0;
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_bram_fifo.sv
// Directed vector table plus hand-written multi-cycle sequences for bram_fifo.
module tb_bram_fifo;

    logic clk;

    // Default-parameter instance.
    logic        rst0_n, iv0, ir0, ov0, or0, af0;
    logic [7:0]  in0, od0;
    logic [10:0] cnt0;

    // Small instance for random stalls.
    logic        rst1_n, iv1, ir1, ov1, or1, af1;
    logic [15:0] in1, od1;
    logic [4:0]  cnt1;

    int n_vec;
    int n_err;

    logic [7:0]  q0[$];
    logic [15:0] q1[$];

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [7:0]  din;
        logic        ordy;
        logic        ev;
        logic [7:0]  ed;
        logic [10:0] ec;
        logic        eir;
    } vec_t;

    vec_t vq[$];

    bram_fifo u_d0 (
        .clk         (clk),
        .rst_n       (rst0_n),
        .in_valid    (iv0),
        .in_ready    (ir0),
        .in_data     (in0),
        .out_valid   (ov0),
        .out_ready   (or0),
        .out_data    (od0),
        .count       (cnt0),
        .almost_full (af0)
    );

    bram_fifo #(
        .WIDTH     (16),
        .ADDR_W    (4),
        .AFULL_LVL (12)
    ) u_d1 (
        .clk         (clk),
        .rst_n       (rst1_n),
        .in_valid    (iv1),
        .in_ready    (ir1),
        .in_data     (in1),
        .out_valid   (ov1),
        .out_ready   (or1),
        .out_data    (od1),
        .count       (cnt1),
        .almost_full (af1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic iv, input logic [7:0] d, input logic o,
                        input logic ev, input logic [7:0] ed, input int ec, input logic eir);
        vec_t v;
        v.rst_n = r;  v.iv = iv;  v.din = d;  v.ordy = o;
        v.ev = ev;    v.ed = ed;  v.ec = 11'(ec);  v.eir = eir;
        vq.push_back(v);
    endtask

    // One cycle on the default instance with a queue model; called at the sample point.
    task automatic d0_cycle(input logic iv, input logic [7:0] d, input logic o);
        logic exp_ir;
        iv0 = iv;
        in0 = d;
        or0 = o;
        exp_ir = (q0.size() < 1024);
        chk("d0_in_ready", 64'(ir0), 64'(exp_ir));
        if (ov0 && o) begin
            if (q0.size() == 0) begin
                chk("d0_pop_when_empty", 64'(ov0), 64'(0));
            end else begin
                chk("d0_out_data", 64'(od0), 64'(q0[0]));
                void'(q0.pop_front());
            end
        end
        if (iv && exp_ir) q0.push_back(d);
        @(posedge clk);
        #1;
        chk("d0_count", 64'(cnt0), 64'(q0.size()));
        chk("d0_almost_full", 64'(af0), 64'(q0.size() >= 1020));
    endtask

    task automatic d0_reset();
        rst0_n = 1'b0; iv0 = 1'b0; or0 = 1'b0; in0 = 8'h00;
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
    endtask

    initial begin
        int cyc;
        int first_v;
        int got;
        logic stall;
        logic [15:0] prev_od;

        n_vec  = 0;
        n_err  = 0;
        rst0_n = 1'b0; iv0 = 1'b0; or0 = 1'b0; in0 = 8'h00;
        rst1_n = 1'b0; iv1 = 1'b0; or1 = 1'b0; in1 = 16'h0000;

        // r  iv  din   or  ev  ed    cnt ir
        addv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);  // reset values
        addv(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);  // in_ready after release
        addv(1, 1, 8'hA5, 0, 0, 8'h00, 1, 1);  // push A5 (edge 1)
        addv(1, 0, 8'h00, 0, 0, 8'h00, 1, 1);  // edge 2: fetching
        addv(1, 0, 8'h00, 0, 1, 8'hA5, 1, 1);  // edge 3: presented
        addv(1, 0, 8'h00, 0, 1, 8'hA5, 1, 1);  // held while stalled
        addv(1, 1, 8'h11, 0, 1, 8'hA5, 2, 1);  // push behind, still stalled
        addv(1, 0, 8'h00, 1, 1, 8'h11, 1, 1);  // pop with prefetch, no bubble
        addv(1, 0, 8'h00, 1, 0, 8'h00, 0, 1);  // last pop -> empty
        addv(1, 1, 8'h22, 1, 0, 8'h00, 1, 1);  // out_ready with nothing valid
        addv(1, 1, 8'h33, 1, 0, 8'h00, 2, 1);
        addv(1, 0, 8'h00, 0, 1, 8'h22, 2, 1);
        addv(1, 1, 8'h44, 1, 1, 8'h33, 2, 1);  // simultaneous push and pop
        addv(1, 0, 8'h00, 1, 1, 8'h44, 1, 1);
        addv(1, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        addv(1, 1, 8'h01, 0, 0, 8'h00, 1, 1);  // build up 7 words
        addv(1, 1, 8'h02, 0, 0, 8'h00, 2, 1);
        addv(1, 1, 8'h03, 0, 1, 8'h01, 3, 1);
        addv(1, 1, 8'h04, 0, 1, 8'h01, 4, 1);
        addv(1, 1, 8'h05, 0, 1, 8'h01, 5, 1);
        addv(1, 1, 8'h06, 0, 1, 8'h01, 6, 1);
        addv(1, 1, 8'h07, 0, 1, 8'h01, 7, 1);
        addv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);  // mid-operation reset
        addv(1, 1, 8'h3C, 0, 0, 8'h00, 0, 1);  // offer refused: in_ready still low
        addv(1, 1, 8'h3C, 0, 0, 8'h00, 1, 1);  // push 3C
        addv(1, 0, 8'h00, 0, 0, 8'h00, 1, 1);
        addv(1, 0, 8'h00, 0, 1, 8'h3C, 1, 1);  // first word after reset is 3C
        addv(1, 0, 8'h00, 1, 0, 8'h00, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst0_n = vq[i].rst_n;
            iv0    = vq[i].iv;
            in0    = vq[i].din;
            or0    = vq[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(ov0),  64'(vq[i].ev));
            chk($sformatf("vec%0d_out_data", i),  64'(od0),  64'(vq[i].ed));
            chk($sformatf("vec%0d_count", i),     64'(cnt0), 64'(vq[i].ec));
            chk($sformatf("vec%0d_in_ready", i),  64'(ir0),  64'(vq[i].eir));
            chk($sformatf("vec%0d_almost_full", i), 64'(af0), 64'(0));
        end

        // Fill to capacity, refuse an extra offer, then full push+pop.
        d0_reset();
        for (int i = 0; i < 1024; i++) d0_cycle(1'b1, 8'(i), 1'b0);
        chk("fill_count", 64'(cnt0), 64'(1024));
        chk("fill_in_ready", 64'(ir0), 64'(0));
        chk("fill_almost_full", 64'(af0), 64'(1));
        d0_cycle(1'b1, 8'hEE, 1'b0);
        chk("fill_refused_count", 64'(cnt0), 64'(1024));
        d0_cycle(1'b1, 8'hEF, 1'b1);
        chk("full_simul_count", 64'(cnt0), 64'(1023));
        chk("full_simul_in_ready", 64'(ir0), 64'(1));
        chk("full_simul_next_word", 64'(od0), 64'(1));
        cyc = 0;
        while (q0.size() > 0 && cyc < 2000) begin
            chk("drain_no_bubble", 64'(ov0), 64'(1));
            d0_cycle(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        chk("drain_done", 64'(q0.size()), 64'(0));
        chk("drain_empty_valid", 64'(ov0), 64'(0));

        // Streaming 3000 words with out_ready held high.
        d0_reset();
        cyc = 0;
        first_v = 0;
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ov0) got++;
            d0_cycle(1'b1, 8'(i * 7 + 3), 1'b1);
            cyc++;
            if (first_v == 0 && ov0) begin
                first_v = cyc;
                chk("stream_latency", 64'(cyc), 64'(3));
            end
            if (first_v != 0) chk("stream_no_bubble", 64'(ov0), 64'(1));
            chk("stream_count_max", 64'(cnt0 <= 11'd3), 64'(1));
        end
        cyc = 0;
        while (q0.size() > 0 && cyc < 20) begin
            if (ov0) got++;
            chk("stream_tail_no_bubble", 64'(ov0), 64'(1));
            d0_cycle(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        chk("stream_words_out", 64'(got), 64'(3000));
        chk("stream_drained", 64'(cnt0), 64'(0));

        // Random 50% valid/ready on the 16-deep instance.
        rst1_n = 1'b0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rnd_reset_count", 64'(cnt1), 64'(0));
        stall = 1'b0;
        prev_od = '0;
        for (int c = 0; c < 10000; c++) begin
            logic exp_ir;
            iv1 = 1'($urandom_range(0, 1));
            or1 = 1'($urandom_range(0, 1));
            in1 = 16'($urandom);
            exp_ir = (q1.size() < 16);
            chk("rnd_in_ready", 64'(ir1), 64'(exp_ir));
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    chk("rnd_pop_when_empty", 64'(ov1), 64'(0));
                end else begin
                    chk("rnd_out_data", 64'(od1), 64'(q1[0]));
                    void'(q1.pop_front());
                end
            end
            if (iv1 && exp_ir) q1.push_back(in1);
            stall   = ov1 && !or1;
            prev_od = od1;
            @(posedge clk);
            #1;
            chk("rnd_count", 64'(cnt1), 64'(q1.size()));
            chk("rnd_almost_full", 64'(af1), 64'(q1.size() >= 12));
            if (stall) begin
                chk("rnd_stall_valid", 64'(ov1), 64'(1));
                chk("rnd_stall_data", 64'(od1), 64'(prev_od));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
